// File: rtl/captura_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel capture stage.
package captura_pkg;

    typedef enum logic {
        CARGA = 1'b0,
        LISTO = 1'b1
    } estado_t;

    localparam int ANCHO_DEF = 8;

    // Counter must be able to represent 0..ANCHO.
    function automatic int cnt_w(input int ancho);
        return $clog2(ancho + 1);
    endfunction

endpackage

// File: rtl/captura_serie_contador_bits.sv
// Modulo-ANCHO bit counter with synchronous clear and load-to-1.
module contador_bits #(
    parameter int ANCHO = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             load1_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ultimo_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign ultimo_o = (cnt_q == CNT_W'(ANCHO - 1));
    assign cnt_o    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i) begin
            cnt_d = ultimo_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/captura_serie.sv
// Serial-to-parallel capture: assembles ANCHO-bit words MSB first under
// valid/ready on both sides, with start-of-word resynchronisation.
module captura_serie
    import captura_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     din,
    input  logic                     din_valid,
    input  logic                     din_sof,
    output logic                     din_ready,
    output logic [ANCHO-1:0]         q,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic                     err_trama,
    output logic [cnt_w(ANCHO)-1:0]  cnt
);

    localparam int CNT_W = cnt_w(ANCHO);

    generate
        if (ANCHO < 2) begin : g_chk_ancho
            $error("captura_serie: ANCHO must be >= 2");
        end
    endgenerate

    estado_t          state_q, state_d;
    logic [ANCHO-1:0] sr_q, sr_d;
    logic [ANCHO-1:0] q_q, q_d;
    logic             err_q, err_d;
    logic             acepta;
    logic             c_inc, c_load, c_clr, c_ultimo;

    contador_bits #(
        .ANCHO (ANCHO),
        .CNT_W (CNT_W)
    ) u_contador (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (c_inc),
        .load1_i  (c_load),
        .clr_i    (c_clr),
        .cnt_o    (cnt),
        .ultimo_o (c_ultimo)
    );

    assign acepta    = din_valid && din_ready;
    assign q         = q_q;
    assign q_valid   = (state_q == LISTO);
    assign err_trama = err_q;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        q_d       = q_q;
        err_d     = 1'b0;
        c_inc     = 1'b0;
        c_load    = 1'b0;
        c_clr     = 1'b0;
        din_ready = (state_q == CARGA) ? 1'b1 : q_ready;

        case (state_q)
            CARGA: begin
                if (acepta) begin
                    if (din_sof) begin
                        sr_d   = ANCHO'(din);
                        c_load = 1'b1;
                        err_d  = (cnt != '0);
                    end else begin
                        sr_d = {sr_q[ANCHO-2:0], din};
                        if (c_ultimo) begin
                            q_d     = {sr_q[ANCHO-2:0], din};
                            c_clr   = 1'b1;
                            state_d = LISTO;
                        end else begin
                            c_inc = 1'b1;
                        end
                    end
                end
            end
            LISTO: begin
                // A bit accepted alongside consumption opens the next word
                // with no gap cycle; cnt is 0 here so din_sof cannot flag.
                if (q_ready) begin
                    state_d = CARGA;
                    if (acepta) begin
                        sr_d   = ANCHO'(din);
                        c_load = 1'b1;
                    end
                end
            end
            default: state_d = CARGA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CARGA;
            sr_q    <= '0;
            q_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/captura_serie.md
Name: captura_serie

Overview:
- Serial-to-parallel capture stage feeding the ANCHO-bit `a` vector of the downstream cell chain (the `bloque` ripple reduction).
- Accepts one bit per cycle under a valid/ready handshake and assembles ANCHO-bit words, MSB first.
- Presents each completed word under a valid/ready handshake and holds it stable until consumed.
- Supports frame resynchronisation via a start-of-word marker and reports broken frames.

Parameters:
- ANCHO, 8, output word width; must be >= 2 (elaboration-time assertion).

Ports:
- clk       input   1      single clock, rising edge
- rst_n     input   1      reset, asynchronous, active-low
- din       input   1      serial data bit
- din_valid input   1      din is valid this cycle
- din_sof   input   1      qualifies din as first (MSB) bit of a new word; only meaningful with din_valid
- din_ready output  1      stage can accept a bit this cycle
- q         output  ANCHO  assembled word; drives downstream `a`
- q_valid   output  1      q holds a complete word
- q_ready   input   1      downstream consumes q this cycle
- err_trama output  1      one-cycle pulse: partial word discarded by din_sof
- cnt       output  $clog2(ANCHO+1)  bits collected in current partial word

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=CARGA, shift register=0, cnt=0, q=0, q_valid=0, err_trama=0.
  - din_ready=1 once reset releases.
- Handshakes:
  - Bit accepted on a rising edge with din_valid && din_ready.
  - Word consumed on a rising edge with q_valid && q_ready.
- Shift rule: accepted bit enters at the LSB and the register shifts left, so the first bit received ends at q[ANCHO-1].
- States (typedef enum):
  - CARGA:
    - din_ready=1, q_valid=0.
    - Each accepted bit: shift, cnt++.
    - Accepting bit with cnt==ANCHO-1: q <= completed word, q_valid <= 1, cnt <= 0, next state LISTO.
  - LISTO:
    - q_valid=1; q is stable while !q_ready.
    - din_ready = q_ready (combinational), so back-to-back streaming is possible.
    - On q_ready without an accepted bit: q_valid <= 0, next state CARGA.
    - On q_ready with an accepted bit: that bit becomes bit 1 of the new word, cnt <= 1, next state CARGA.
    - q keeps its last value after consumption; only q_valid drops.
- Latency:
  - Last bit accepted at edge N → q_valid=1 after edge N.
  - Minimum word period is ANCHO cycles with q_ready tied high.
- din_sof:
  - When accepted, the shift register restarts with this bit and cnt <= 1.
  - If cnt was not 0 (partial word lost): err_trama=1 for exactly one cycle.
  - din_sof with cnt==0 produces no error.
  - din_sof on a bit that is not accepted has no effect.
- Ignored inputs:
  - din_valid while din_ready=0: bit not taken, no state change. The upstream source must hold the bit.
  - q_ready while q_valid=0 is ignored.
- Simultaneous events in LISTO (q_ready, din_valid, din_sof all high): word consumed, new word starts with cnt=1, no err_trama.
- Reset mid-word or mid-LISTO: partial word and pending q are discarded; all outputs return to reset values immediately.
- Width rules:
  - cnt never exceeds ANCHO-1 in CARGA and is 0 in LISTO.
  - No arithmetic on q.

Decomposition:
- Package captura_pkg holds:
  - typedef enum logic {CARGA, LISTO} estado_t
  - function/localparam for counter width CNT_W = $clog2(ANCHO+1)
- One natural sub-module: contador_bits (parameterised modulo-ANCHO counter with synchronous load-to-1 for din_sof/back-to-back and clear).
- Shift register and FSM live in the top.

Test Plan:
- Reset, then stream 8 bits 1,0,1,1,0,0,1,0 with din_valid=1, q_ready=0 → q=8'hB2, q_valid rises after the 8th edge, din_ready=0 and q held for 5 stall cycles.
- Same word, then q_ready=1 with the next bit 1 in the same cycle → word consumed, cnt=1, no gap cycle. A continuous stream of 8'hB2, 8'h5A yields one q_valid per 8 cycles.
- After 3 bits of a word, assert din_sof with bit 1 → err_trama pulses once, cnt=1. The following 7 bits 0,0,0,0,0,0,1 give q=8'h81.
- din_sof on the very first bit after reset → err_trama stays 0. din_valid toggling 1/0 every cycle takes 16 cycles to produce one word.
- In LISTO, drive din_valid=1 with q_ready=0 for 4 cycles → no bits lost or taken, cnt=0, q unchanged.
- Assert rst_n low mid-word (cnt=5) and separately while q_valid=1 → q=0, q_valid=0, cnt=0 immediately, without waiting for a clock edge.
